// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : BCD HH:MM:SS timekeeper with debounced two-button time-set FSM
//            and blink control for the 7-segment scan multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel,
    output logic       set_active
);

    // State codes double as the blink_sel value for the selected field.
    typedef enum logic [1:0] {
        SET_HH = 2'd0,
        SET_MM = 2'd1,
        SET_SS = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int c_DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int c_TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST = (TIMEOUT_S > 0) ? c_TW'(TIMEOUT_S - 1) : '0;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            bcd_inc = 8'h00;
        else if (v[3:0] == 4'd9)
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [1:0] w_raw;
    logic [1:0] w_press;
    assign w_raw = {btn_inc, btn_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]      r_sync;
            logic [c_DW-1:0] r_cnt;
            logic            r_db;
            logic            r_db_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= 2'b00;
                    r_cnt  <= '0;
                    r_db   <= 1'b0;
                    r_db_q <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    r_db_q <= r_db;
                    if (r_sync[1] == r_db)
                        r_cnt <= '0;
                    else if (r_cnt == c_DB_LAST) begin
                        r_db  <= r_sync[1];
                        r_cnt <= '0;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_press[gi] = r_db & ~r_db_q;
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_TW-1:0] r_to_cnt;
    logic            r_phase;
    logic            w_phase_nxt;
    logic            w_mode_press;
    logic            w_inc_press;
    logic            w_any_press;
    logic            w_timeout;

    assign w_mode_press = w_press[0];
    assign w_inc_press  = w_press[1] & ~w_press[0];
    assign w_any_press  = |w_press;
    assign w_timeout    = (TIMEOUT_S != 0) && set_active && tick_1hz &&
                          !w_any_press && (r_to_cnt == c_TO_LAST);
    assign w_phase_nxt  = w_any_press ? 1'b0 : (tick_2hz ? ~r_phase : r_phase);

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_press) begin
            case (r_state)
                RUN:     w_state_nxt = SET_HH;
                SET_HH:  w_state_nxt = SET_MM;
                SET_MM:  w_state_nxt = SET_SS;
                default: w_state_nxt = RUN;
            endcase
        end else if (w_timeout)
            w_state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            blink_sel  <= 2'b11;
            set_active <= 1'b0;
            blink_en   <= 1'b0;
            r_phase    <= 1'b0;
            r_to_cnt   <= '0;
            hh         <= 8'h00;
            mm         <= 8'h00;
            ss         <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            blink_sel  <= w_state_nxt;
            set_active <= (w_state_nxt != RUN);
            r_phase    <= w_phase_nxt;
            blink_en   <= w_phase_nxt & (w_state_nxt != RUN);

            if (w_any_press || (w_state_nxt != r_state) || !set_active)
                r_to_cnt <= '0;
            else if (tick_1hz)
                r_to_cnt <= r_to_cnt + 1'b1;

            // Time only advances in RUN; SET states edit a single field without carry.
            if (r_state == RUN) begin
                if (tick_1hz) begin
                    ss <= bcd_inc(ss, 8'h59);
                    if (ss == 8'h59)
                        mm <= bcd_inc(mm, 8'h59);
                    if (ss == 8'h59 && mm == 8'h59)
                        hh <= bcd_inc(hh, 8'h23);
                end
            end else if (w_inc_press) begin
                case (r_state)
                    SET_HH:  hh <= bcd_inc(hh, 8'h23);
                    SET_MM:  mm <= bcd_inc(mm, 8'h59);
                    default: ss <= bcd_inc(ss, 8'h59);
                endcase
            end
        end
    end

endmodule
`default_nettype wire
